id_ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-selection stage that sits directly upstream of the ALU in the RV32IM pipeline. It captures decoded instruction fields and applies EX/MEM and MEM/WB forwarding. It drives the ALU operand inputs data1/data2/opcode. It also detects load-use hazards, supports hold (STALL) and squash (FLUSH), and passes control bits on to EX/MEM.

---
 rtl/rv32_pipe_pkg.sv | 51 +++++
 rtl/id_ex_operand_stage_fwd_select.sv | 38 +++
 rtl/id_ex_operand_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_operand_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared RV32IM pipeline types: widths, ALU opcodes, forward-select codes
// and the ID/EX stage register bundle.
package rv32_pipe_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SRL    = 5'b00110;
    localparam logic [4:0] ALU_SRA    = 5'b00111;
    localparam logic [4:0] ALU_SLTU   = 5'b01000;
    localparam logic [4:0] ALU_MUL    = 5'b01001;
    localparam logic [4:0] ALU_MULH   = 5'b01010;
    localparam logic [4:0] ALU_MULHSU = 5'b01011;
    localparam logic [4:0] ALU_MULHU  = 5'b01100;
    localparam logic [4:0] ALU_DIV    = 5'b01101;
    localparam logic [4:0] ALU_DIVU   = 5'b01110;
    localparam logic [4:0] ALU_REM    = 5'b01111;
    localparam logic [4:0] ALU_SLT    = 5'b10000;
    localparam logic [4:0] ALU_PASS   = 5'b10001;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // All-zero value of this struct is the bubble.
    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [RADDR_W-1:0] rs1_addr;
        logic [RADDR_W-1:0] rs2_addr;
        logic [RADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]    imm;
        logic [4:0]         alu_op;
        logic               src1_pc;
        logic               src2_imm;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Forwarding mux for one source operand: EX/MEM beats MEM/WB, x0 never forwarded.
// Ports: src_addr/src_data in, both downstream write ports in, fwd_data/fwd_sel out.
module fwd_select
    import rv32_pipe_pkg::*;
(
    input  logic [RADDR_W-1:0] src_addr,
    input  logic [XLEN-1:0]    src_data,
    input  logic [RADDR_W-1:0] exmem_rd_addr,
    input  logic               exmem_reg_write,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic [RADDR_W-1:0] memwb_rd_addr,
    input  logic               memwb_reg_write,
    input  logic [XLEN-1:0]    memwb_result,
    output logic [XLEN-1:0]    fwd_data,
    output fwd_sel_e           fwd_sel
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write && (exmem_rd_addr != '0)
                       && (exmem_rd_addr == src_addr);
    assign memwb_hit = memwb_reg_write && (memwb_rd_addr != '0)
                       && (memwb_rd_addr == src_addr);

    always_comb begin
        fwd_sel  = FWD_NONE;
        fwd_data = src_data;
        if (exmem_hit) begin
            fwd_sel  = FWD_EXMEM;
            fwd_data = exmem_result;
        end else if (memwb_hit) begin
            fwd_sel  = FWD_MEMWB;
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding, load-use detect, STALL and FLUSH.
// Ports: CLK/RESET/STALL/FLUSH, id_* decode fields, downstream write ports, ALU/EX outputs.
module id_ex_operand_stage
    import rv32_pipe_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               STALL,
    input  logic               FLUSH,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [4:0]         id_alu_op,
    input  logic               id_src1_pc,
    input  logic               id_src2_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic [RADDR_W-1:0] exmem_rd_addr,
    input  logic [RADDR_W-1:0] memwb_rd_addr,
    input  logic               exmem_reg_write,
    input  logic               memwb_reg_write,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic [XLEN-1:0]    memwb_result,
    output logic [XLEN-1:0]    data1,
    output logic [XLEN-1:0]    data2,
    output logic [4:0]         opcode,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [XLEN-1:0]    ex_pc,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               load_use_stall
);

    id_ex_t ex_q;
    id_ex_t ex_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    fwd_sel_e        fwd1_sel;
    fwd_sel_e        fwd2_sel;

    fwd_select u_fwd_rs1 (
        .src_addr        (ex_q.rs1_addr),
        .src_data        (ex_q.rs1_data),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs1),
        .fwd_sel         (fwd1_sel)
    );

    fwd_select u_fwd_rs2 (
        .src_addr        (ex_q.rs2_addr),
        .src_data        (ex_q.rs2_data),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs2),
        .fwd_sel         (fwd2_sel)
    );

    assign load_use_stall = ex_q.valid && ex_q.mem_read
                            && (ex_q.rd_addr != '0) && id_valid
                            && ((ex_q.rd_addr == id_rs1_addr)
                             || (ex_q.rd_addr == id_rs2_addr));

    always_comb begin
        ex_d = ex_q;
        if (FLUSH) begin
            ex_d = '0;
        end else if (STALL) begin
            // Latch a forwarded value so a producer retiring mid-stall is kept.
            if (fwd1_sel != FWD_NONE) ex_d.rs1_data = fwd_rs1;
            if (fwd2_sel != FWD_NONE) ex_d.rs2_data = fwd_rs2;
        end else if (load_use_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.pc        = id_pc;
            ex_d.rs1_data  = id_rs1_data;
            ex_d.rs2_data  = id_rs2_data;
            ex_d.rs1_addr  = id_rs1_addr;
            ex_d.rs2_addr  = id_rs2_addr;
            ex_d.rd_addr   = id_rd_addr;
            ex_d.imm       = id_imm;
            ex_d.alu_op    = id_alu_op;
            ex_d.src1_pc   = id_src1_pc;
            ex_d.src2_imm  = id_src2_imm;
            // Control is qualified by valid so a non-instruction never writes.
            ex_d.reg_write = id_valid && id_reg_write;
            ex_d.mem_read  = id_valid && id_mem_read;
            ex_d.mem_write = id_valid && id_mem_write;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign data1         = ex_q.src1_pc ? ex_q.pc : fwd_rs1;
    assign data2         = ex_q.src2_imm ? ex_q.imm : fwd_rs2;
    assign opcode        = ex_q.alu_op;
    assign ex_store_data = fwd_rs2;
    assign ex_pc         = ex_q.pc;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding, hazards,
// STALL/FLUSH priority and operand select, hand-computed expectations.
module tb_id_ex_operand_stage;

    logic        CLK = 1'b0;
    logic        RESET, STALL, FLUSH;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op;
    logic        id_src1_pc, id_src2_imm;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  exmem_rd_addr, memwb_rd_addr;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] data1, data2, ex_store_data, ex_pc;
    logic [4:0]  opcode, ex_rd_addr;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        load_use_stall;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    id_ex_operand_stage dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_imm(id_imm), .id_alu_op(id_alu_op),
        .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write),
        .exmem_rd_addr(exmem_rd_addr), .memwb_rd_addr(memwb_rd_addr),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .data1(data1), .data2(data2), .opcode(opcode),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_stall(load_use_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [4:0] op, input logic s1pc,
                          input logic s2imm, input logic rw,
                          input logic mr, input logic mw);
        id_valid = v; id_pc = pc;
        id_rs1_addr = a1; id_rs1_data = d1;
        id_rs2_addr = a2; id_rs2_data = d2;
        id_rd_addr = rd; id_imm = imm; id_alu_op = op;
        id_src1_pc = s1pc; id_src2_imm = s2imm;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_down(input logic ew, input logic [4:0] ea,
                            input logic [31:0] er, input logic mw,
                            input logic [4:0] ma, input logic [31:0] mr);
        exmem_reg_write = ew; exmem_rd_addr = ea; exmem_result = er;
        memwb_reg_write = mw; memwb_rd_addr = ma; memwb_result = mr;
    endtask

    initial begin
        RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
        // Non-zero ID fields while reset is held must not leak through.
        set_id(1, 32'h40, 5'd1, 32'h5, 5'd2, 32'h7, 5'd3, 32'h9,
               5'b00001, 0, 0, 1, 1, 1);
        set_down(0, 0, 0, 0, 0, 0);
        step(); step();
        chk("rst_data1", data1, 32'h0);
        chk("rst_data2", data2, 32'h0);
        chk("rst_opcode", {27'd0, opcode}, 32'h0);
        chk("rst_valid", {31'd0, ex_valid}, 32'h0);
        chk("rst_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'h0);
        chk("rst_lus", {31'd0, load_use_stall}, 32'h0);
        RESET = 1'b0;

        // Basic load: ADD x5 = x1 + x2
        set_id(1, 32'h40, 5'd1, 32'h5, 5'd2, 32'h7, 5'd5, 32'h0,
               5'b00000, 0, 0, 1, 0, 0);
        step();
        chk("ld_data1", data1, 32'h5);
        chk("ld_data2", data2, 32'h7);
        chk("ld_opcode", {27'd0, opcode}, 32'h0);
        chk("ld_valid", {31'd0, ex_valid}, 32'h1);
        chk("ld_rd", {27'd0, ex_rd_addr}, 32'h5);
        chk("ld_rw", {31'd0, ex_reg_write}, 32'h1);

        // Double-match forwarding on rs1 = x3 (register value 1)
        set_id(1, 32'h44, 5'd3, 32'h1, 5'd0, 32'h0, 5'd6, 32'h0,
               5'b00001, 0, 0, 1, 0, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0);
        set_down(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
        #1 chk("fwd_exmem_wins", data1, 32'hAA);
        chk("fwd_opcode_sub", {27'd0, opcode}, 32'h1);
        exmem_reg_write = 1'b0;
        #1 chk("fwd_memwb", data1, 32'hBB);
        set_down(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
        #1 chk("fwd_x0_none", data1, 32'h1);
        set_down(0, 0, 0, 0, 0, 0);

        // Load-use: LW x4 in EX, consumer reads rs2 = x4
        set_id(1, 32'h48, 5'd1, 32'h5, 5'd0, 32'h0, 5'd4, 32'h0,
               5'b00000, 0, 1, 1, 1, 0);
        step();
        set_id(1, 32'h4C, 5'd5, 32'h50, 5'd4, 32'h0, 5'd6, 32'h0,
               5'b00000, 0, 0, 1, 0, 0);
        #1 chk("lu_stall", {31'd0, load_use_stall}, 32'h1);
        step();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'h0);
        chk("lu_bubble_rw", {31'd0, ex_reg_write}, 32'h0);
        chk("lu_released", {31'd0, load_use_stall}, 32'h0);
        set_down(0, 0, 0, 1, 5'd4, 32'hDEAD);
        step();
        chk("lu_cons_valid", {31'd0, ex_valid}, 32'h1);
        chk("lu_cons_rd", {27'd0, ex_rd_addr}, 32'h6);
        chk("lu_cons_data1", data1, 32'h50);
        chk("lu_cons_data2", data2, 32'hDEAD);
        set_down(0, 0, 0, 0, 0, 0);

        // Forward captured during a 3-cycle STALL
        set_id(1, 32'h50, 5'd7, 32'h11, 5'd0, 32'h0, 5'd8, 32'h0,
               5'b00000, 0, 0, 1, 0, 0);
        step();
        chk("st_pre", data1, 32'h11);
        STALL = 1'b1;
        set_id(1, 32'h54, 5'd9, 32'h9999, 5'd0, 32'h0, 5'd10, 32'h0,
               5'b00010, 0, 0, 1, 0, 0);
        set_down(0, 0, 0, 1, 5'd7, 32'h1234);
        step();
        set_down(0, 0, 0, 0, 0, 0);
        #1 chk("st_c1", data1, 32'h1234);
        step(); step();
        chk("st_held_data1", data1, 32'h1234);
        chk("st_held_rd", {27'd0, ex_rd_addr}, 32'h8);
        chk("st_held_pc", ex_pc, 32'h50);
        STALL = 1'b0;

        // FLUSH beats STALL with a valid SW in ID
        STALL = 1'b1; FLUSH = 1'b1;
        set_id(1, 32'h58, 5'd1, 32'h100, 5'd2, 32'h200, 5'd0, 32'h8,
               5'b00000, 0, 1, 0, 0, 1);
        step();
        chk("fl_valid", {31'd0, ex_valid}, 32'h0);
        chk("fl_mw", {31'd0, ex_mem_write}, 32'h0);
        chk("fl_data1", data1, 32'h0);
        STALL = 1'b0; FLUSH = 1'b0;

        // PC / immediate select, store data follows forwarded rs2
        set_id(1, 32'h100, 5'd1, 32'h33, 5'd2, 32'h77, 5'd0, 32'hFFFFFFFC,
               5'b10001, 1, 1, 0, 0, 1);
        step();
        chk("sel_data1", data1, 32'h100);
        chk("sel_data2", data2, 32'hFFFFFFFC);
        chk("sel_store", ex_store_data, 32'h77);
        chk("sel_opcode", {27'd0, opcode}, 32'h11);
        chk("sel_mw", {31'd0, ex_mem_write}, 32'h1);
        set_down(1, 5'd2, 32'hCAFE, 0, 0, 0);
        #1 chk("sel_store_fwd", ex_store_data, 32'hCAFE);
        chk("sel_data2_imm", data2, 32'hFFFFFFFC);
        set_down(0, 0, 0, 0, 0, 0);

        // Invalid ID slot never asserts control
        set_id(0, 32'h104, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0,
               5'b00000, 0, 0, 1, 1, 1);
        step();
        chk("inv_ctrl", {28'd0, ex_valid, ex_reg_write, ex_mem_read,
                         ex_mem_write}, 32'h0);

        // Asynchronous reset mid-cycle discards the instruction
        set_id(1, 32'h108, 5'd1, 32'h44, 5'd2, 32'h2, 5'd3, 32'h0,
               5'b00001, 0, 0, 1, 0, 0);
        step();
        chk("ar_pre_valid", {31'd0, ex_valid}, 32'h1);
        #2 RESET = 1'b1;
        #1 chk("ar_valid", {31'd0, ex_valid}, 32'h0);
        chk("ar_data1", data1, 32'h0);
        chk("ar_rw", {31'd0, ex_reg_write}, 32'h0);
        RESET = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
